dcm_phaseshift_multi: RTL
=========================

# dcm_phaseshift_multi

Parametrised multi-channel phase-shift controller that drives the variable phase-shift ports (PSEN/PSINCDEC/PSDONE) of NCH clock managers from a single register-side request interface. For each channel it tracks the actual phase in signed steps and walks it to a requested target one step at a time. Target requests are clamped to a configured range. The block aborts on DCM overflow, on psdone timeout, and on loss of lock. It sits between the capture-control registers and the DCM_SP instances in the clock-management layer, clocked by the phase-shift clock.

## Interface
- NCH, 2: number of DCM channels (1-8)
- WIDTH, 10: signed phase value width (two's complement)
- MIN_PHASE, -255: lowest permitted target; requests below it are clamped
- MAX_PHASE, 255: highest permitted target; requests above it are clamped
- TIMEOUT, 1023: maximum cycles to wait for psdone after a PSEN pulse
- clk_i  in  1  phase-shift clock; one clock domain; also drives the DCM PSCLK pins
- reset_i  in  1  synchronous, active-high reset
- load_i  in  1  single-cycle request strobe; accepted only while busy_o=0
- ch_sel_i  in  max(1,$clog2(NCH))  channel targeted by load_i; values ≥NCH are ignored
- value_i  in  WIDTH  signed target phase, sampled with load_i
- value_o  out  NCH*WIDTH  actual phase per channel; channel k is at [k*WIDTH +: WIDTH]
- busy_o  out  1  a request is in progress
- done_o  out  1  one-cycle pulse when a request finishes (success or abort)
- status_o  out  3  result of the last request: [0] clamped, [1] overflow abort, [2] timeout/unlock abort; held until the next accepted load
- dcm_psen_o  out  NCH  per-channel PSEN; single-cycle pulses
- dcm_psincdec_o  out  NCH  per-channel PSINCDEC: 1=increment, 0=decrement
- dcm_psdone_i  in  NCH  per-channel PSDONE
- dcm_psovf_i  in  NCH  per-channel phase-shift overflow (DCM STATUS[0])
- dcm_locked_i  in  NCH  per-channel LOCKED

## Operation
- State machine states: IDLE, CHECK, STEP, WAIT, FINISH.
- IDLE:
  - load_i=1 with a valid ch_sel_i latches the channel and the clamped target.
  - status_o[0] is set if the request was clamped; status_o[2:1] are cleared.
  - Next state is CHECK.
- CHECK:
  - If the channel is unlocked: set status_o[2], go to FINISH.
  - Else if actual == target: go to FINISH.
  - Else: go to STEP.
- STEP:
  - Assert PSEN for the selected channel for exactly one cycle.
  - PSINCDEC = (target > actual), valid in the same cycle as PSEN.
  - Clear the timeout counter. Go to WAIT.
- WAIT, on psdone=1:
  - If psovf=1: actual value is unchanged, set status_o[1], go to FINISH.
  - Otherwise: actual ±1, go to CHECK.
- WAIT, on timeout: after TIMEOUT cycles without psdone, set status_o[2] and go to FINISH.
- WAIT, on lock loss: if locked drops, set status_o[2] and go to FINISH.
- FINISH: pulse done_o, go to IDLE.
- Lock loss, any state: while dcm_locked_i[k]=0, channel k's actual value is forced to 0 (an unlocked DCM has been reset to zero phase).
- Only the selected channel is ever stepped; other channels' PSEN outputs stay 0.
- load_i while busy_o=1 is ignored (no queueing). load_i with ch_sel_i ≥ NCH is ignored; done_o is not pulsed.
- Arithmetic:
  - Comparisons are signed, WIDTH bits.
  - MIN_PHASE and MAX_PHASE must fit in WIDTH.
  - The actual value never leaves [MIN_PHASE, MAX_PHASE], so no wrap-around.
- psdone arriving outside WAIT, or on a non-selected channel, is ignored.

## Timing
- All outputs are registered.
- Reset values: value_o=0, busy_o=0, done_o=0, status_o=0, dcm_psen_o=0, dcm_psincdec_o=0.
- State after reset is IDLE.
- Cycle-level sequence (load_i sampled at edge 0):
  - busy_o goes high after edge 0, in the CHECK state.
  - First PSEN is high after edge 1.
  - WAIT begins after edge 2.
- If psdone is sampled at edge n, value_o updates after edge n; CHECK runs at n+1 and the next PSEN is high after edge n+2.
- A step with psdone returned d cycles after PSEN costs d+2 cycles.
- Zero-distance request: done_o pulses after edge 2, busy_o falls after edge 3.
- done_o and the final status_o are valid in the same cycle. busy_o falls in the cycle after done_o.
- Timeout: abort occurs exactly TIMEOUT cycles after the PSEN cycle if psdone has not arrived.
- Synchronous reset mid-operation:
  - Returns to IDLE next edge.
  - Drops PSEN immediately.
  - Zeros all actual values. DCMs must share the reset so hardware phase matches.

## Test plan
- Basic stepping: ch0 locked, psdone returned 3 cycles after each PSEN, load value_i=5 -> exactly 5 PSEN pulses with psincdec=1, value_o[ch0]=5, done_o once, status_o=000.
- Decrement and clamp: from ch1=+2, load value_i=-300 (WIDTH=10) -> status_o[0]=1, 257 decrement pulses, value_o[ch1]=-255, ch0 PSEN never asserted.
- Overflow abort: at actual=10, drive psovf=1 with the 4th psdone of a +20 request -> value_o=13, status_o=010, done_o pulses, no further PSEN.
- Timeout: TIMEOUT=16, psdone never returned -> done_o exactly 16 cycles after the first PSEN, status_o=100, value_o unchanged.
- Lock loss and rejection:
  - Drop dcm_locked_i[0] mid-walk -> value_o[ch0]=0, status_o=100.
  - load_i while busy -> ignored.
  - ch_sel_i=NCH -> no response.
- Reset mid-walk: assert reset_i during WAIT -> PSEN, busy_o and value_o are 0 next cycle; a new load then succeeds from 0.

Source files
------------

// File: rtl/dcm_phaseshift_multi.sv
// Multi-channel DCM variable phase-shift controller. It walks the selected channel's
// phase to a clamped target one PSEN step at a time, and aborts on overflow, timeout or unlock.
module dcm_phaseshift_multi #(
  parameter int NCH       = 2,
  parameter int WIDTH     = 10,
  parameter int MIN_PHASE = -255,
  parameter int MAX_PHASE = 255,
  parameter int TIMEOUT   = 1023,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [CW-1:0]          ch_sel_i,
  input  logic signed [WIDTH-1:0] value_i,
  output logic [NCH*WIDTH-1:0]   value_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [2:0]             status_o,
  output logic [NCH-1:0]         dcm_psen_o,
  output logic [NCH-1:0]         dcm_psincdec_o,
  input  logic [NCH-1:0]         dcm_psdone_i,
  input  logic [NCH-1:0]         dcm_psovf_i,
  input  logic [NCH-1:0]         dcm_locked_i
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // WAIT is entered two edges after the PSEN edge and done_o follows FINISH by one,
  // so the abort fires at this count to land done_o TIMEOUT cycles after PSEN.
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 3) ? TIMEOUT - 3 : 0);
  localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(MIN_PHASE);
  localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(MAX_PHASE);
  localparam logic signed [WIDTH-1:0] ONE_V = WIDTH'(1);

  typedef enum logic [2:0] {IDLE, CHECK, STEP, WAIT, FINISH} state_t;

  state_t                  state_q;
  logic [CW-1:0]           sel_q;
  logic signed [WIDTH-1:0] tgt_q;
  logic signed [WIDTH-1:0] act_q [NCH];
  logic [TW-1:0]           tmo_q;
  logic                    busy_q;
  logic                    done_q;
  logic [2:0]              status_q;
  logic [NCH-1:0]          psen_q;
  logic [NCH-1:0]          incdec_q;

  logic signed [WIDTH-1:0] tgt_d;
  logic                    clamp_d;
  logic                    accept_d;
  logic signed [WIDTH-1:0] act_sel;
  logic                    lock_sel;
  logic                    psdone_sel;
  logic                    psovf_sel;

  function automatic logic signed [WIDTH-1:0] sat_phase(input logic signed [WIDTH-1:0] v);
    if (v < MIN_V) return MIN_V;
    if (v > MAX_V) return MAX_V;
    return v;
  endfunction

  function automatic logic is_clamped(input logic signed [WIDTH-1:0] v);
    return (v < MIN_V) || (v > MAX_V);
  endfunction

  function automatic logic signed [WIDTH-1:0] step_phase(input logic signed [WIDTH-1:0] v,
                                                          input logic up);
    return up ? (v + ONE_V) : (v - ONE_V);
  endfunction

  always_comb begin
    tgt_d      = sat_phase(value_i);
    clamp_d    = is_clamped(value_i);
    accept_d   = (state_q == IDLE) && !busy_q && load_i && (int'(ch_sel_i) < NCH);
    act_sel    = act_q[sel_q];
    lock_sel   = dcm_locked_i[sel_q];
    psdone_sel = dcm_psdone_i[sel_q];
    psovf_sel  = dcm_psovf_i[sel_q];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      tgt_q    <= '0;
      tmo_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= '0;
      psen_q   <= '0;
      incdec_q <= '0;
      for (int k = 0; k < NCH; k++) act_q[k] <= '0;
    end else begin
      psen_q <= '0;
      done_q <= (state_q == FINISH);
      busy_q <= accept_d || (state_q != IDLE);
      // An unlocked DCM has been reset to zero phase; track that here.
      for (int k = 0; k < NCH; k++) begin
        if (!dcm_locked_i[k]) act_q[k] <= '0;
      end
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            sel_q    <= ch_sel_i;
            tgt_q    <= tgt_d;
            status_q <= {2'b00, clamp_d};
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          if (!lock_sel) begin
            status_q[2] <= 1'b1;
            state_q     <= FINISH;
          end else if (act_sel == tgt_q) begin
            state_q <= FINISH;
          end else begin
            psen_q[sel_q]   <= 1'b1;
            incdec_q[sel_q] <= (tgt_q > act_sel);
            state_q         <= STEP;
          end
        end
        STEP: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (!lock_sel) begin
            status_q[2] <= 1'b1;
            state_q     <= FINISH;
          end else if (psdone_sel) begin
            if (psovf_sel) begin
              status_q[1] <= 1'b1;
              state_q     <= FINISH;
            end else begin
              act_q[sel_q] <= step_phase(act_sel, incdec_q[sel_q]);
              state_q      <= CHECK;
            end
          end else if (tmo_q >= TMO_LAST) begin
            status_q[2] <= 1'b1;
            state_q     <= FINISH;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_val
    assign value_o[k*WIDTH +: WIDTH] = act_q[k];
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign status_o       = status_q;
  assign dcm_psen_o     = psen_q;
  assign dcm_psincdec_o = incdec_q;

endmodule
